// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU memory port.
// Splits each CPU access between block RAM (low space, aliased modulo the
// BRAM depth) and a small bank of memory-mapped I/O registers at IO_BASE:
// LEDs, synchronized switches, latched button-press events and a ms timer.
// Read data appears one cycle after the address for both spaces, matching
// the synchronous BRAM, so the CPU sees a single uniform read latency.
module mem_io_responder #(
  parameter int              WIDTH     = 16,
  parameter int              ADDR_BITS = 10,
  parameter logic [WIDTH-1:0] IO_BASE  = 16'hFF00,
  parameter int              TIMER_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mem_addr,
  input  logic [WIDTH-1:0]     writedata,
  input  logic                 MEM_WR_S,
  output logic [WIDTH-1:0]     mem_out,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_din,
  output logic                 ram_we,
  input  logic [WIDTH-1:0]     ram_dout,
  input  logic [9:0]           sw,
  input  logic [3:0]           btn,
  output logic [9:0]           leds
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  localparam logic [WIDTH-1:0] OFF_LEDS  = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_SW    = WIDTH'(1);
  localparam logic [WIDTH-1:0] OFF_BTNEV = WIDTH'(2);
  localparam logic [WIDTH-1:0] OFF_TIMER = WIDTH'(3);

  logic             io;
  logic [WIDTH-1:0] io_off;
  logic             wr_io;
  logic             wr_leds;
  logic             wr_btnev;
  logic             wr_timer;
  logic [WIDTH-1:0] io_rd;
  logic [3:0]       btn_fall;

  logic [9:0]       leds_q, leds_d;
  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [3:0]       btn_s1_q, btn_s2_q, btn_prev_q;
  logic [3:0]       ev_q, ev_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] io_q, io_d;
  logic             out_en_q;

  assign io       = (mem_addr >= IO_BASE);
  assign io_off   = mem_addr - IO_BASE;
  assign wr_io    = MEM_WR_S & io;
  assign wr_leds  = wr_io && (io_off == OFF_LEDS);
  assign wr_btnev = wr_io && (io_off == OFF_BTNEV);
  assign wr_timer = wr_io && (io_off == OFF_TIMER);
  assign btn_fall = btn_prev_q & ~btn_s2_q;

  assign ram_addr = mem_addr[ADDR_BITS-1:0];
  assign ram_din  = writedata;
  assign ram_we   = MEM_WR_S & ~io;
  assign leds     = leds_q;

  // out_en_q holds the output at 0 from reset until the first edge after release
  assign mem_out = out_en_q ? (sel_q ? io_q : ram_dout) : '0;

  // I/O read mux; unmapped offsets read as zero
  always_comb begin
    io_rd = '0;
    if (io) begin
      case (io_off)
        OFF_LEDS:  io_rd = WIDTH'(leds_q);
        OFF_SW:    io_rd = WIDTH'(sw_s2_q);
        OFF_BTNEV: io_rd = WIDTH'(ev_q);
        OFF_TIMER: io_rd = timer_q;
        default:   io_rd = '0;
      endcase
    end
  end

  // Next-state for the writable registers, prescaler and read pipeline
  always_comb begin
    leds_d  = wr_leds ? writedata[9:0] : leds_q;
    // a fresh edge outranks a same-cycle W1C clear
    ev_d    = (ev_q & ~(wr_btnev ? writedata[3:0] : 4'h0)) | btn_fall;
    presc_d = presc_q;
    timer_d = timer_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      timer_d = timer_q + WIDTH'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // a CPU load outranks a same-cycle tick
    if (wr_timer) begin
      timer_d = writedata;
      presc_d = '0;
    end
    sel_d = io;
    io_d  = io_rd;
  end

  // Register state; button flops reset high so a released button shows no edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q     <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= 4'hF;
      btn_s2_q   <= 4'hF;
      btn_prev_q <= 4'hF;
      ev_q       <= '0;
      timer_q    <= '0;
      presc_q    <= '0;
      sel_q      <= 1'b0;
      io_q       <= '0;
      out_en_q   <= 1'b0;
    end else begin
      leds_q     <= leds_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      ev_q       <= ev_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      io_q       <= io_d;
      out_en_q   <= 1'b1;
    end
  end

endmodule
